// File: rtl/game_stage_controller.sv
// game_stage_controller: fighter-game stage sequencer (START/BATTLE/WIN/LOSE) with player health tracking
module game_stage_controller #(
  parameter int MAX_HP = 100,
  parameter int HIT_DMG = 10,
  parameter int HP_W = 7,
  parameter int END_FRAMES = 180,
  parameter logic [7:0] START_KEY = 8'h28
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_clk,
  input  logic [7:0]      keycode,
  input  logic            hit_p1,
  input  logic            hit_p2,
  output logic            start_l,
  output logic            battle_l,
  output logic            win_l,
  output logic            lose_l,
  output logic [HP_W-1:0] p1_hp,
  output logic [HP_W-1:0] p2_hp
);
  localparam int FC_W = $clog2(END_FRAMES) > 0 ? $clog2(END_FRAMES) : 1;
  localparam logic [HP_W-1:0] MAX = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0] DMG = HP_W'(HIT_DMG);
  localparam logic [FC_W-1:0] LAST = FC_W'(END_FRAMES - 1);
  typedef enum logic [1:0] {START, BATTLE, WIN, LOSE} state_t;
  state_t state, state_n;
  logic [HP_W-1:0] p1_n, p2_n;
  logic [FC_W-1:0] cnt, cnt_n;
  logic frame_clk_d, key_armed, frame_tick, start_ok;
  assign frame_tick = frame_clk & ~frame_clk_d;
  assign start_ok = (keycode == START_KEY) && key_armed;
  assign start_l = state == START;
  assign battle_l = state == BATTLE;
  assign win_l = state == WIN;
  assign lose_l = state == LOSE;
  always_comb begin
    state_n = state;
    p1_n = p1_hp;
    p2_n = p2_hp;
    cnt_n = cnt;
    case (state)
      START: if (start_ok) begin
        state_n = BATTLE;
        p1_n = MAX;
        p2_n = MAX;
      end
      BATTLE: begin
        p1_n = hit_p1 ? (p1_hp <= DMG ? '0 : p1_hp - DMG) : p1_hp;
        p2_n = hit_p2 ? (p2_hp <= DMG ? '0 : p2_hp - DMG) : p2_hp;
        cnt_n = '0;
        // decided on registered health, so the stage changes one cycle after the final hit
        state_n = p1_hp == '0 ? LOSE : p2_hp == '0 ? WIN : BATTLE;
      end
      WIN, LOSE: if (frame_tick) begin
        cnt_n = cnt == LAST ? '0 : cnt + 1'b1;
        state_n = cnt == LAST ? START : state;
      end
      default: state_n = START;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= START;
      p1_hp <= MAX;
      p2_hp <= MAX;
      cnt <= '0;
      frame_clk_d <= 1'b0;
      key_armed <= 1'b0;
    end else begin
      state <= state_n;
      p1_hp <= p1_n;
      p2_hp <= p2_n;
      cnt <= cnt_n;
      frame_clk_d <= frame_clk;
      // a start-key press always consumes the arm, so a held key can never start twice
      key_armed <= keycode != START_KEY;
    end
  end
endmodule

// File: tb/tb_game_stage_controller.sv
// tb_game_stage_controller: scoreboard bench for the stage sequencer, with a second MAX_HP=95 instance for saturation
module tb_game_stage_controller;
  logic Clk = 0, Reset = 1, frame_clk = 0, hit_p1 = 0, hit_p2 = 0;
  logic [7:0] keycode = 0;
  logic start_l, battle_l, win_l, lose_l, s2, b2, w2, l2;
  logic [6:0] p1_hp, p2_hp, q1_hp, q2_hp;
  typedef struct {string name; logic [24:0] v;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0;
  localparam logic [3:0] S = 4'b1000, B = 4'b0100, W = 4'b0010, L = 4'b0001;

  always #5 Clk = ~Clk;

  game_stage_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .hit_p1(hit_p1), .hit_p2(hit_p2), .start_l(start_l), .battle_l(battle_l),
    .win_l(win_l), .lose_l(lose_l), .p1_hp(p1_hp), .p2_hp(p2_hp));

  game_stage_controller #(.MAX_HP(95)) dut95 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .hit_p1(hit_p1), .hit_p2(hit_p2), .start_l(s2), .battle_l(b2),
    .win_l(w2), .lose_l(l2), .p1_hp(q1_hp), .p2_hp(q2_hp));

  function automatic logic [24:0] ex(logic [3:0] f, int p1, int p2, int q2);
    return {f, 7'(p1), 7'(p2), 7'(q2)};
  endfunction

  function automatic logic [24:0] obs();
    return {start_l, battle_l, win_l, lose_l, p1_hp, p2_hp, q2_hp};
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_reset();
    Reset = 1;
    tick(2);
    sb.push_back('{name: "reset_hold", v: ex(S, 100, 100, 95)});
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    Reset = 0;
    sb.push_back('{name: "reset_release", v: ex(S, 100, 100, 95)});
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
  endtask

  task automatic test_key_arm();
    Reset = 1;
    keycode = 8'h28;
    tick();
    Reset = 0;
    sb.push_back('{name: "held_through_reset", v: ex(S, 100, 100, 95)});
    tick(3);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    keycode = 8'h00;
    tick();
    keycode = 8'h28;
    sb.push_back('{name: "start_press", v: ex(B, 100, 100, 95)});
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    keycode = 8'h00;
    tick();
  endtask

  task automatic test_win();
    for (int i = 0; i < 9; i++) begin
      hit_p2 = 1; tick(); hit_p2 = 0; tick();
    end
    sb.push_back('{name: "nine_hits", v: ex(B, 100, 10, 5)});
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    hit_p2 = 1;
    sb.push_back('{name: "final_hit_saturate", v: ex(B, 100, 0, 0)});
    tick();
    hit_p2 = 0;
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    sb.push_back('{name: "win_entry", v: ex(W, 100, 0, 0)});
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
  endtask

  task automatic test_frames();
    sb.push_back('{name: "win_179_edges", v: ex(W, 100, 0, 0)});
    frame_clk = 1; tick(5); frame_clk = 0; tick();
    for (int i = 0; i < 178; i++) begin
      frame_clk = 1; tick(); frame_clk = 0; tick();
    end
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    frame_clk = 1;
    sb.push_back('{name: "win_180th_edge", v: ex(S, 100, 0, 0)});
    tick();
    frame_clk = 0;
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    tick();
  endtask

  task automatic test_lose();
    keycode = 8'h00; tick(); keycode = 8'h28;
    sb.push_back('{name: "reentry_reload", v: ex(B, 100, 100, 95)});
    tick();
    keycode = 8'h00;
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    hit_p1 = 1; hit_p2 = 1;
    tick(9);
    hit_p1 = 0; hit_p2 = 0;
    sb.push_back('{name: "both_at_10", v: ex(B, 10, 10, 5)});
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    hit_p1 = 1; hit_p2 = 1;
    sb.push_back('{name: "simultaneous_hit", v: ex(B, 0, 0, 0)});
    tick();
    hit_p1 = 0; hit_p2 = 0;
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    sb.push_back('{name: "lose_priority", v: ex(L, 0, 0, 0)});
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    keycode = 8'h28;
    for (int i = 0; i < 180; i++) begin
      frame_clk = 1; tick(); frame_clk = 0; tick();
    end
    sb.push_back('{name: "key_held_across_stage", v: ex(S, 0, 0, 0)});
    tick(3);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    keycode = 8'h00;
    tick();
  endtask

  task automatic test_async_reset();
    keycode = 8'h28; tick(); keycode = 8'h00;
    for (int i = 0; i < 6; i++) begin
      hit_p1 = 1; tick(); hit_p1 = 0; tick();
    end
    sb.push_back('{name: "p1_at_40", v: ex(B, 40, 100, 95)});
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    #2 Reset = 1;
    sb.push_back('{name: "async_reset_no_edge", v: ex(S, 100, 100, 95)});
    #1;
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
    tick();
    Reset = 0;
    sb.push_back('{name: "after_async_release", v: ex(S, 100, 100, 95)});
    tick(2);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, obs(), e.v); end
  endtask

  initial begin
    test_reset();
    test_key_arm();
    test_win();
    test_frames();
    test_lose();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
